// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin command FIFO arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_NUM_REQ   = 4;
  localparam int unsigned ARB_REQ_LOG2  = 2;
  localparam int unsigned ARB_MAX_BEATS = 256;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request strictly after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned REQ_LOG2 = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_LOG2-1:0] ptr,
  output logic                found,
  output logic [REQ_LOG2-1:0] idx
);

  logic [REQ_LOG2-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // i runs 1..NUM_REQ so the previous winner (ptr) is scanned last
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = REQ_LOG2'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with registered outputs and registered s_ready.
module skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign s_ready = !skid_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (m_ready || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_valid;
        if (s_valid) out_data_d = s_data;
      end
    end else if (s_valid && !skid_valid_q) begin
      // output stalled: park the beat accepted this cycle
      skid_valid_d = 1'b1;
      skid_data_d  = s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// N-to-1 burst-locked round-robin arbiter in front of a command FIFO.
// Define FIFO_ARB_OUT_SKID_EN to register the m_* side through a skid_buffer.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
  parameter int unsigned REQ_LOG2   = ARB_REQ_LOG2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = ARB_MAX_BEATS
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [REQ_LOG2-1:0]           m_id,
  output logic                          busy,
  output logic                          burst_err
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  arb_state_e          state_q, state_d;
  logic [REQ_LOG2-1:0] grant_q, grant_d;
  logic [REQ_LOG2-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                burst_err_q, burst_err_d;

  logic                  pick_found;
  logic [REQ_LOG2-1:0]   pick_idx;
  logic                  arb_valid, arb_ready, arb_last;
  logic [DATA_WIDTH-1:0] arb_data;
  logic [REQ_LOG2-1:0]   arb_id;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_LOG2(REQ_LOG2)
  ) u_pick (
    .req  (s_valid),
    .ptr  (ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign busy      = (state_q == ARB_LOCK);
  assign burst_err = burst_err_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    burst_err_d = burst_err_q;
    arb_valid   = 1'b0;
    arb_data    = '0;
    arb_last    = 1'b0;
    arb_id      = '0;
    s_ready     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        arb_valid        = s_valid[grant_q];
        arb_data         = s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        arb_last         = s_last[grant_q];
        arb_id           = grant_q;
        s_ready[grant_q] = arb_ready;
        if (arb_valid && arb_ready) begin
          // counter sits at MAX_BEATS, so this handshake is beat MAX_BEATS+1
          if (cnt_q == CNT_MAX) burst_err_d = 1'b1;
          else                  cnt_d       = cnt_q + 1'b1;
          if (arb_last) begin
            ptr_d   = grant_q;
            cnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      ptr_q       <= REQ_LOG2'(NUM_REQ - 1);
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

`ifdef FIFO_ARB_OUT_SKID_EN
  localparam int unsigned SKID_W = DATA_WIDTH + 1 + REQ_LOG2;

  logic [SKID_W-1:0] skid_out;

  skid_buffer #(
    .WIDTH(SKID_W)
  ) u_out_skid (
    .clk    (clk),
    .rst_n  (resetn),
    .s_valid(arb_valid),
    .s_ready(arb_ready),
    .s_data ({arb_data, arb_last, arb_id}),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (skid_out)
  );

  assign {m_data, m_last, m_id} = skid_out;
`else
  assign arb_ready = m_ready;
  assign m_valid   = arb_valid;
  assign m_data    = arb_data;
  assign m_last    = arb_last;
  assign m_id      = arb_id;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: random bursts against a queue-based reference.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

  localparam int NR = 4;
  localparam int LG = 2;
  localparam int DW = 16;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NR-1:0]    s_valid, s_ready, s_last;
  logic [NR*DW-1:0] s_data;
  logic             m_valid, m_ready, m_last, busy, burst_err;
  logic [DW-1:0]    m_data;
  logic [LG-1:0]    m_id;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .NUM_REQ   (NR),
    .REQ_LOG2  (LG),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_id     (m_id),
    .busy     (busy),
    .burst_err(burst_err)
  );

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    logic        last;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    dut_win_log[$];
  bit    first_beat;

  // requester-side stimulus state
  logic [DW-1:0] bdata[NR][8];
  int            blen[NR];
  int            bpos[NR];
  bit            bact[NR];
  bit            hs[NR];
  bit            req_en[NR];
  int            gen_pct, val_pct, rdy_pct, fix_len, rdy_mode, cyc;

  // reference model state
  bit md_lock, md_err;
  int md_w, md_ptr, md_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_s_ready"},   64'(s_ready),   64'(0));
    chk({tag, "_m_valid"},   64'(m_valid),   64'(0));
    chk({tag, "_m_last"},    64'(m_last),    64'(0));
    chk({tag, "_m_id"},      64'(m_id),      64'(0));
    chk({tag, "_m_data"},    64'(m_data),    64'(0));
    chk({tag, "_burst_err"}, 64'(burst_err), 64'(0));
  endtask

  task automatic drive_cycle();
    cyc++;
    for (int k = 0; k < NR; k++)
      if (hs[k]) begin
        bpos[k]++;
        if (bpos[k] >= blen[k]) bact[k] = 1'b0;
      end
    for (int k = 0; k < NR; k++)
      if (!bact[k] && req_en[k] && ($urandom_range(99) < gen_pct)) begin
        blen[k] = (fix_len > 0) ? fix_len : int'($urandom_range(4, 1));
        bpos[k] = 0;
        for (int j = 0; j < 8; j++) bdata[k][j] = DW'($urandom);
        bact[k] = 1'b1;
      end
    for (int k = 0; k < NR; k++) begin
      s_valid[LG'(k)]       = bact[k] && ($urandom_range(99) < val_pct);
      s_data[k*DW +: DW]    = bdata[k][bpos[k]];
      s_last[LG'(k)]        = bact[k] && (bpos[k] == blen[k] - 1);
    end
    if (rdy_mode == 1) m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else               m_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic set_req(input bit r0, input bit r1, input bit r2, input bit r3);
    req_en[0] = r0; req_en[1] = r1; req_en[2] = r2; req_en[3] = r3;
  endtask

  function automatic bit all_idle();
    bit idle = !md_lock;
    for (int k = 0; k < NR; k++) if (bact[k]) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string tag);
    int t;
    gen_pct = 0; val_pct = 100; rdy_mode = 0; rdy_pct = 100;
    t = 0;
    while (!all_idle() && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain_timeout: got busy expected idle within 300 cycles", tag);
    end
    repeat (2) step();
    chk({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  // monitor + reference model, sampled on the falling edge
  initial begin
    beat_t       b;
    logic [NR-1:0] exp_rdy;
    bit          found, mhs;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        md_lock = 1'b0; md_w = 0; md_ptr = NR - 1; md_cnt = 0; md_err = 1'b0;
        exp_q.delete();
        dut_win_log.delete();
        first_beat = 1'b1;
        for (int k = 0; k < NR; k++) hs[k] = 1'b0;
      end else begin
        chk("busy",      64'(busy),      64'(md_lock));
        chk("burst_err", 64'(burst_err), 64'(md_err));
`ifndef FIFO_ARB_OUT_SKID_EN
        exp_rdy = '0;
        if (md_lock) exp_rdy[LG'(md_w)] = m_ready;
        chk("s_ready", 64'(s_ready), 64'(exp_rdy));
        chk("m_valid", 64'(m_valid), 64'(md_lock && s_valid[LG'(md_w)]));
`endif
        if (m_valid && m_ready) begin
          if (first_beat) dut_win_log.push_back(int'(m_id));
          first_beat = m_last;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_beat: got id %0d data %0h expected no beat", m_id, m_data);
          end else begin
            b = exp_q.pop_front();
            chk("m_id",   64'(m_id),   64'(b.id));
            chk("m_data", 64'(m_data), 64'(b.data));
            chk("m_last", 64'(m_last), 64'(b.last));
          end
        end
        for (int k = 0; k < NR; k++) hs[k] = s_valid[LG'(k)] && s_ready[LG'(k)];
        if (!md_lock) begin
          found = 1'b0;
          for (int i = 1; i <= NR; i++)
            if (!found && s_valid[LG'((md_ptr + i) % NR)]) begin
              found = 1'b1;
              md_w  = (md_ptr + i) % NR;
            end
          if (found) begin
            md_lock = 1'b1;
            md_cnt  = 0;
            for (int j = 0; j < blen[md_w]; j++) begin
              b.id = md_w; b.data = bdata[md_w][j]; b.last = (j == blen[md_w] - 1);
              exp_q.push_back(b);
            end
          end
        end else begin
`ifdef FIFO_ARB_OUT_SKID_EN
          mhs = s_valid[LG'(md_w)] && s_ready[LG'(md_w)];
`else
          mhs = s_valid[LG'(md_w)] && m_ready;
`endif
          if (mhs) begin
            if (md_cnt >= MB) md_err = 1'b1;
            if (md_cnt == blen[md_w] - 1) begin
              md_lock = 1'b0;
              md_ptr  = md_w;
            end
            md_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    resetn = 1'b0; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0; cyc = 0;
    for (int k = 0; k < NR; k++) begin bact[k] = 1'b0; bpos[k] = 0; blen[k] = 1; end
    gen_pct = 0; val_pct = 100; rdy_pct = 100; fix_len = 0; rdy_mode = 0;
    set_req(1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #3;
    check_reset("por");

    // all four contending with 2-beat bursts: grant order 0,1,2,3,0,...
    gen_pct = 100; fix_len = 2;
    @(posedge clk); #1; resetn = 1'b1; drive_cycle();
    t = 0;
    while (dut_win_log.size() < 8 && t < 200) begin step(); t++; end
    if (dut_win_log.size() < 8) begin
      n_checks++; n_fail++;
      $display("FAIL contention_timeout: got %0d bursts expected 8", dut_win_log.size());
    end else
      for (int i = 0; i < 8; i++) chk("contention_order", 64'(dut_win_log[i]), 64'(i % 4));
    drain("contention");

    // random traffic with valid gaps and backpressure
    gen_pct = 30; val_pct = 80; rdy_pct = 70; fix_len = 0;
    repeat (1500) step();
    drain("random");

    // requester 2 alone, 4 beats, m_ready pattern 1,0,0,1
    set_req(0, 0, 1, 0);
    gen_pct = 100; fix_len = 4; rdy_mode = 1; cyc = 0;
    t = 0;
    while (!bact[2] && t < 20) begin step(); t++; end
    gen_pct = 0;
    t = 0;
    while (!all_idle() && t < 60) begin step(); t++; end
    drain("backpressure");

    // requesters 0 and 3 with valid gaps mid-burst
    set_req(1, 0, 0, 1);
    gen_pct = 100; fix_len = 4; val_pct = 60; rdy_pct = 100;
    repeat (80) step();
    drain("valid_gap");

    // reset while requester 1 presents beat 3
    set_req(0, 1, 0, 0);
    gen_pct = 100; fix_len = 4; val_pct = 100; rdy_pct = 100;
    t = 0;
    while (!(bact[1] && bpos[1] == 2) && t < 50) begin step(); t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL midreset_setup_timeout: got no beat 3 expected beat 3 within 50 cycles");
    end
    #1; resetn = 1'b0;
    #1; check_reset("midreset");
    for (int k = 0; k < NR; k++) bact[k] = 1'b0;
    s_valid = '0;
    repeat (2) @(posedge clk);
    set_req(1, 1, 0, 1);
    fix_len = 0;
    @(posedge clk); #1; resetn = 1'b1; drive_cycle();
    t = 0;
    while (dut_win_log.size() < 1 && t < 50) begin step(); t++; end
    if (dut_win_log.size() < 1) begin
      n_checks++; n_fail++;
      $display("FAIL post_reset_timeout: got no burst expected one within 50 cycles");
    end else
      chk("post_reset_first_grant", 64'(dut_win_log[0]), 64'(0));
    drain("post_reset");

    // requester 1 sends MAX_BEATS+1 beats
    set_req(0, 1, 0, 0);
    gen_pct = 100; fix_len = MB + 1; val_pct = 100; rdy_pct = 70;
    t = 0;
    while (!bact[1] && t < 20) begin step(); t++; end
    gen_pct = 0;
    t = 0;
    while (!all_idle() && t < 100) begin step(); t++; end
    drain("overlength");
    chk("burst_err_set", 64'(burst_err), 64'(1));
    set_req(1, 0, 0, 0);
    gen_pct = 100; fix_len = 2;
    repeat (10) step();
    drain("after_err");
    chk("burst_err_sticky", 64'(burst_err), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
